// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch queue.
//   FETCH_W     : width of one fetch word
//   fq_state_e  : fetch control state (RUN / DRAIN_STALL)
//   fq_entry_t  : queue entry {word (little-endian order), pc, pc_2}
//   swap_bytes  : big-endian cache word -> little-endian instruction order
package if_pkg;

    localparam int unsigned FETCH_W = 32;

    typedef logic [FETCH_W-1:0] fetch_word_t;

    typedef enum logic {
        FQ_RUN         = 1'b0,
        FQ_DRAIN_STALL = 1'b1
    } fq_state_e;

    typedef struct packed {
        fetch_word_t word;
        logic [31:0] pc;
        logic        pc_2;
    } fq_entry_t;

    function automatic fetch_word_t swap_bytes(input fetch_word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a synchronous flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : drop all entries this edge (wins over push/pop)
//   push        : write push_data (ignored when full)
//   push_data   : entry to write
//   pop         : remove head (ignored when empty)
//   head_data   : head entry, all-zero when empty
//   head_valid  : FIFO not empty
//   count       : number of valid entries
module fq_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    output fq_entry_t                head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    fq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Storage has no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to the I-cache,
// buffers byte-swapped fetch words with their PC, and handles redirects,
// including redirects that arrive while a cache request is stalled.
//   clk, rst_n          : clock, asynchronous active-low reset
//   icache_req/addr     : cache read request and word address (PC[31:2])
//   icache_rdata/stall  : cache read data (big-endian), request not done
//   redirect_valid/pc   : one-cycle redirect and halfword-aligned target
//   out_valid/word/pc   : head entry toward the aligner
//   out_pc_2            : head word is a redirect target at upper halfword
//   out_ready           : aligner consumes head this cycle
//   count               : number of valid entries
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     icache_req,
    output logic [29:0]              icache_addr,
    input  logic [31:0]              icache_rdata,
    input  logic                     icache_stall,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    output logic [31:0]              out_word,
    output logic [31:0]              out_pc,
    output logic                     out_pc_2,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_state_e   state;
    fq_state_e   state_next;
    logic [31:0] fetch_pc;
    logic        pc_2_flag;
    logic [31:1] pending_pc;

    logic        done;
    logic        fifo_flush;
    logic        fifo_push;
    fq_entry_t   push_data;
    fq_entry_t   head_data;
    logic        pc_load;
    logic [31:1] pc_load_val;
    logic        pc_adv;
    logic        pend_load;
    logic        unused_redirect_bit0;

    assign unused_redirect_bit0 = redirect_pc[0];

    // In DRAIN_STALL the stalled request stays asserted until it completes;
    // its response is then dropped. rst_n gating keeps the request low
    // while reset is held.
    assign icache_req  = rst_n && ((state == FQ_DRAIN_STALL) || (count < CW'(DEPTH)));
    assign icache_addr = fetch_pc[31:2];
    assign done        = icache_req && !icache_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FQ_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fifo_flush  = 1'b0;
        fifo_push   = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = fetch_pc[31:1];
        pc_adv      = 1'b0;
        pend_load   = 1'b0;
        unique case (state)
            FQ_RUN: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    if (icache_req && icache_stall) begin
                        pend_load  = 1'b1;
                        state_next = FQ_DRAIN_STALL;
                    end else begin
                        pc_load     = 1'b1;
                        pc_load_val = redirect_pc[31:1];
                    end
                end else if (done) begin
                    fifo_push = 1'b1;
                    pc_adv    = 1'b1;
                end
            end
            FQ_DRAIN_STALL: begin
                fifo_flush = redirect_valid;
                if (done) begin
                    // A redirect landing on the completion cycle is the latest target.
                    state_next  = FQ_RUN;
                    pc_load     = 1'b1;
                    pc_load_val = redirect_valid ? redirect_pc[31:1] : pending_pc;
                end else if (redirect_valid) begin
                    pend_load = 1'b1;
                end
            end
            default: state_next = FQ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= {RESET_PC[31:2], 2'b00};
            pc_2_flag  <= 1'b0;
            pending_pc <= '0;
        end else begin
            if (pc_load) begin
                fetch_pc  <= {pc_load_val[31:2], 2'b00};
                pc_2_flag <= pc_load_val[1];
            end else if (pc_adv) begin
                fetch_pc  <= fetch_pc + 32'd4;
                pc_2_flag <= 1'b0;
            end
            if (pend_load) begin
                pending_pc <= redirect_pc[31:1];
            end
        end
    end

    always_comb begin
        push_data      = '0;
        push_data.word = swap_bytes(icache_rdata);
        push_data.pc   = fetch_pc;
        push_data.pc_2 = pc_2_flag;
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_data  (push_data),
        .pop        (out_ready),
        .head_data  (head_data),
        .head_valid (out_valid),
        .count      (count)
    );

    assign out_word = head_data.word;
    assign out_pc   = head_data.pc;
    assign out_pc_2 = head_data.pc_2;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_word;
    logic [31:0] out_pc;
    logic        out_pc_2;
    logic        out_ready;
    logic [2:0]  count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic        exp_pc2;
    bit          model_on;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_rdata   (icache_rdata),
        .icache_stall   (icache_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_word       (out_word),
        .out_pc         (out_pc),
        .out_pc_2       (out_pc_2),
        .out_ready      (out_ready),
        .count          (count)
    );

    function automatic logic [31:0] model_rdata(input logic [29:0] a);
        return {a[7:0], 8'hC3, 8'h3C, ~a[7:0]};
    endfunction

    function automatic logic [31:0] le(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (model_on) icache_rdata = model_rdata(icache_addr);
    endtask

    task automatic sb_check();
        if (out_ready && out_valid) begin
            chk("sb_pc", out_pc, exp_pc);
            chk("sb_word", out_word, le(model_rdata(exp_pc[31:2])));
            chk("sb_pc2", {31'b0, out_pc_2}, {31'b0, exp_pc2});
            exp_pc  = exp_pc + 32'd4;
            exp_pc2 = 1'b0;
        end
    endtask

    task automatic step();
        sb_check();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        icache_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        icache_rdata   = 32'h1300_0000;
        model_on       = 1'b0;
        exp_pc         = '0;
        exp_pc2        = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_req", {31'b0, icache_req}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_pc2", {31'b0, out_pc_2}, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("first_req", {31'b0, icache_req}, 32'd1);
        chk("first_addr", {2'b0, icache_addr}, 32'd0);

        // Streaming, one word per cycle, constant nop data
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stream_addr", {2'b0, icache_addr}, 32'(i + 1));
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_word", out_word, 32'h0000_0013);
            chk("stream_pc", out_pc, 32'(i * 4));
            chk("stream_count", {29'b0, count}, 32'd1);
        end

        // Switch to address-dependent data; head pc16 drains first
        model_on     = 1'b1;
        icache_rdata = model_rdata(icache_addr);
        tick();
        exp_pc  = 32'd20;
        exp_pc2 = 1'b0;

        // Back-pressure fills the queue and gates requests
        out_ready = 1'b0;
        repeat (10) step();
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_req", {31'b0, icache_req}, 32'd0);
        chk("full_head", out_pc, 32'd20);
        out_ready = 1'b1;
        step();
        chk("resume_req", {31'b0, icache_req}, 32'd1);
        chk("resume_count", {29'b0, count}, 32'd3);
        repeat (6) step();
        chk("steady_count", {29'b0, count}, 32'd3);

        // Redirect to upper halfword with the queue full
        out_ready = 1'b0;
        repeat (3) step();
        chk("full2_count", {29'b0, count}, 32'd4);
        chk("full2_req", {31'b0, icache_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, out_valid}, 32'd0);
        chk("redir_count", {29'b0, count}, 32'd0);
        chk("redir_req", {31'b0, icache_req}, 32'd1);
        chk("redir_addr", {2'b0, icache_addr}, 32'h40);
        exp_pc    = 32'h100;
        exp_pc2   = 1'b1;
        out_ready = 1'b1;
        step();
        chk("redir_head_pc", out_pc, 32'h100);
        chk("redir_head_pc2", {31'b0, out_pc_2}, 32'd1);
        step();
        chk("redir_next_pc", out_pc, 32'h104);
        chk("redir_next_pc2", {31'b0, out_pc_2}, 32'd0);
        step();
        chk("pre_stall_addr", {2'b0, icache_addr}, 32'h43);

        // Stall for 3 cycles, redirect to 0x200 in the second
        icache_stall = 1'b1;
        step();
        chk("stall1_valid", {31'b0, out_valid}, 32'd0);
        chk("stall1_addr", {2'b0, icache_addr}, 32'h43);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("stall2_valid", {31'b0, out_valid}, 32'd0);
        chk("stall2_count", {29'b0, count}, 32'd0);
        chk("stall2_req", {31'b0, icache_req}, 32'd1);
        chk("stall2_addr", {2'b0, icache_addr}, 32'h43);
        tick();
        chk("stall3_addr", {2'b0, icache_addr}, 32'h43);
        chk("stall3_valid", {31'b0, out_valid}, 32'd0);
        icache_stall = 1'b0;
        tick();
        chk("drop_valid", {31'b0, out_valid}, 32'd0);
        chk("drop_count", {29'b0, count}, 32'd0);
        chk("drop_addr", {2'b0, icache_addr}, 32'h80);
        chk("drop_req", {31'b0, icache_req}, 32'd1);
        exp_pc  = 32'h200;
        exp_pc2 = 1'b0;
        tick();
        chk("tgt_valid", {31'b0, out_valid}, 32'd1);
        chk("tgt_pc", out_pc, 32'h200);
        step();
        step();

        // Two redirects during one stall: the last one wins
        icache_stall   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_pc = 32'h0000_0306;
        tick();
        redirect_valid = 1'b0;
        icache_stall   = 1'b0;
        chk("lw_valid", {31'b0, out_valid}, 32'd0);
        chk("lw_held_addr", {2'b0, icache_addr}, 32'h83);
        tick();
        chk("lw_addr", {2'b0, icache_addr}, 32'hC1);
        chk("lw_valid2", {31'b0, out_valid}, 32'd0);
        exp_pc  = 32'h304;
        exp_pc2 = 1'b1;
        tick();
        chk("lw_pc", out_pc, 32'h304);
        chk("lw_pc2", {31'b0, out_pc_2}, 32'd1);
        step();
        step();

        // Reset pulsed in the middle of a stall
        icache_stall = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_req", {31'b0, icache_req}, 32'd0);
        chk("mrst_count", {29'b0, count}, 32'd0);
        chk("mrst_word", out_word, 32'd0);
        chk("mrst_pc", out_pc, 32'd0);
        chk("mrst_pc2", {31'b0, out_pc_2}, 32'd0);
        tick();
        chk("mrst_req_hold", {31'b0, icache_req}, 32'd0);
        rst_n        = 1'b1;
        icache_stall = 1'b0;
        #1;
        icache_rdata = model_rdata(icache_addr);
        chk("post_rst_req", {31'b0, icache_req}, 32'd1);
        chk("post_rst_addr", {2'b0, icache_addr}, 32'd0);
        exp_pc  = 32'd0;
        exp_pc2 = 1'b0;
        tick();
        chk("post_rst_pc", out_pc, 32'd0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
